// File: rtl/rps_pkg.sv
// Shared constants and types for the rock-paper-scissors round driver:
// move/result encodings, game_word field offsets and the round FSM state type.
package rps_pkg;

  localparam logic [1:0] ROCK         = 2'b00;
  localparam logic [1:0] PAPER        = 2'b01;
  localparam logic [1:0] SCISSORS     = 2'b10;
  localparam logic [1:0] MOVE_INVALID = 2'b11;

  localparam logic [1:0] TIE    = 2'b00;
  localparam logic [1:0] P1_WIN = 2'b01;
  localparam logic [1:0] P2_WIN = 2'b10;

  localparam int GW_START_BIT = 0;
  localparam int GW_P1_LSB    = 1;
  localparam int GW_P2_LSB    = 3;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FIRE    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DONE    = 2'd3
  } rps_state_t;

  function automatic logic [7:0] pack_game_word(input logic [1:0] p1_move,
                                                input logic [1:0] p2_move);
    logic [7:0] w;
    w = '0;
    w[GW_START_BIT]       = 1'b1;
    w[GW_P1_LSB +: 2]     = p1_move;
    w[GW_P2_LSB +: 2]     = p2_move;
    return w;
  endfunction

endpackage

// File: rtl/rps_debounce.sv
// Lock-button debouncer: the level follows the raw input only after it has been
// stable for DEBOUNCE_CYCLES samples; rise pulses for one cycle as the level goes high.
module rps_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             rise_reg, rise_next;

  // The counter tracks how long raw has disagreed with the current level.
  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    if (raw == level_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_next   = '0;
      level_next = raw;
      rise_next  = raw;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rise_reg  <= rise_next;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/rps_round_driver.sv
// Player-side round driver: debounced move locking, one-cycle start word, match scoring.
// Optional result timeout enabled by defining RPS_ROUND_TIMEOUT_EN.
module rps_round_driver
  import rps_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCORE_W         = 4,
  parameter int WIN_SCORE       = 3,
  parameter int RESULT_TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         p1_sel,
  input  logic               p1_lock,
  input  logic [1:0]         p2_sel,
  input  logic               p2_lock,
  input  logic               res_valid,
  input  logic [1:0]         res_code,
  input  logic               new_match,
  output logic [7:0]         game_word,
  output logic               p1_locked,
  output logic               p2_locked,
  output logic               busy,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               match_over,
  output logic               round_err
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  rps_state_t              state_reg, state_next;
  logic [1:0]              locked_reg, locked_next;
  logic [1:0][1:0]         move_reg, move_next;
  logic [1:0][SCORE_W-1:0] score_reg, score_next;

  logic [1:0]      lock_raw, lock_level, lock_rise, lock_take;
  logic [1:0][1:0] sel;

  assign lock_raw = {p2_lock, p1_lock};
  assign sel      = {p2_sel, p1_sel};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      rps_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (lock_raw[gi]),
        .level (lock_level[gi]),
        .rise  (lock_rise[gi])
      );
      assign lock_take[gi] = lock_rise[gi] & lock_level[gi] & ~locked_reg[gi]
                           & (sel[gi] != MOVE_INVALID);
    end
  endgenerate

`ifdef RPS_ROUND_TIMEOUT_EN
  localparam int TMO_W = $clog2(RESULT_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic             err_reg, err_next;
`endif

  always_comb begin
    state_next  = state_reg;
    locked_next = locked_reg;
    move_next   = move_reg;
    score_next  = score_reg;
`ifdef RPS_ROUND_TIMEOUT_EN
    tmo_next    = tmo_reg;
    err_next    = 1'b0;
`endif
    if (new_match) begin
      score_next  = '0;
      locked_next = '0;
      state_next  = ST_COLLECT;
    end else begin
      case (state_reg)
        ST_COLLECT: begin
          for (int p = 0; p < 2; p++) begin
            if (lock_take[p]) begin
              locked_next[p] = 1'b1;
              move_next[p]   = sel[p];
            end
          end
          if (&locked_reg) state_next = ST_FIRE;
        end
        ST_FIRE: begin
          state_next = ST_WAIT;
`ifdef RPS_ROUND_TIMEOUT_EN
          tmo_next   = '0;
`endif
        end
        ST_WAIT: begin
          if (res_valid) begin
            if (res_code == P1_WIN && score_reg[0] < WIN_VAL)
              score_next[0] = score_reg[0] + SCORE_W'(1);
            if (res_code == P2_WIN && score_reg[1] < WIN_VAL)
              score_next[1] = score_reg[1] + SCORE_W'(1);
            locked_next = '0;
            state_next  = (score_next[0] == WIN_VAL || score_next[1] == WIN_VAL)
                          ? ST_DONE : ST_COLLECT;
`ifdef RPS_ROUND_TIMEOUT_EN
          // A result arriving on the final wait cycle takes priority over the abort.
          end else if (tmo_reg == TMO_W'(RESULT_TIMEOUT - 1)) begin
            err_next    = 1'b1;
            locked_next = '0;
            state_next  = ST_COLLECT;
          end else begin
            tmo_next = tmo_reg + TMO_W'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_COLLECT;
      locked_reg <= '0;
      move_reg   <= '0;
      score_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      locked_reg <= locked_next;
      move_reg   <= move_next;
      score_reg  <= score_next;
    end
  end

`ifdef RPS_ROUND_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      tmo_reg <= tmo_next;
      err_reg <= err_next;
    end
  end
  assign round_err = err_reg;
`else
  assign round_err = 1'b0;
`endif

  assign game_word  = (state_reg == ST_FIRE) ? pack_game_word(move_reg[0], move_reg[1]) : 8'h00;
  assign p1_locked  = locked_reg[0];
  assign p2_locked  = locked_reg[1];
  assign busy       = (state_reg == ST_FIRE) || (state_reg == ST_WAIT);
  assign match_over = (state_reg == ST_DONE);
  assign p1_score   = score_reg[0];
  assign p2_score   = score_reg[1];

endmodule

// File: tb/tb_rps_round_driver.sv
// Randomized bench for rps_round_driver against a behavioural match model.
module tb_rps_round_driver;

  localparam int DEB = 4;
  localparam int SW  = 4;
  localparam int WIN = 3;
  localparam int TMO = 15;

  localparam int PH_COLLECT = 0;
  localparam int PH_FIRE    = 1;
  localparam int PH_WAIT    = 2;
  localparam int PH_DONE    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    p1_sel = 2'b00;
  logic          p1_lock = 1'b0;
  logic [1:0]    p2_sel = 2'b00;
  logic          p2_lock = 1'b0;
  logic          res_valid = 1'b0;
  logic [1:0]    res_code = 2'b00;
  logic          new_match = 1'b0;
  logic [7:0]    game_word;
  logic          p1_locked, p2_locked, busy, match_over, round_err;
  logic [SW-1:0] p1_score, p2_score;

  rps_round_driver #(
    .DEBOUNCE_CYCLES (DEB),
    .SCORE_W         (SW),
    .WIN_SCORE       (WIN),
    .RESULT_TIMEOUT  (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p1_sel     (p1_sel),
    .p1_lock    (p1_lock),
    .p2_sel     (p2_sel),
    .p2_lock    (p2_lock),
    .res_valid  (res_valid),
    .res_code   (res_code),
    .new_match  (new_match),
    .game_word  (game_word),
    .p1_locked  (p1_locked),
    .p2_locked  (p2_locked),
    .busy       (busy),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .match_over (match_over),
    .round_err  (round_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
  endtask

  // Reference model: debounce via run length of identical raw samples, match by rules.
  int m_run[2];
  bit m_last[2];
  bit m_level[2];
  bit m_rise[2];
  bit m_locked[2];
  int m_move[2];
  int m_score[2];
  int m_phase;
  int m_waited;
  bit m_err;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_run[p] = 0; m_last[p] = 0; m_level[p] = 0; m_rise[p] = 0;
      m_locked[p] = 0; m_move[p] = 0; m_score[p] = 0;
    end
    m_phase = PH_COLLECT;
    m_waited = 0;
    m_err = 0;
  endtask

  task automatic model_step();
    bit raw[2];
    int sv[2];
    bit both, prev;
    raw[0] = p1_lock; raw[1] = p2_lock;
    sv[0] = int'(p1_sel); sv[1] = int'(p2_sel);
    m_err = 0;
    if (new_match) begin
      for (int p = 0; p < 2; p++) begin m_score[p] = 0; m_locked[p] = 0; end
      m_phase = PH_COLLECT;
    end else begin
      case (m_phase)
        PH_COLLECT: begin
          both = m_locked[0] && m_locked[1];
          for (int p = 0; p < 2; p++)
            if (m_rise[p] && sv[p] != 3 && !m_locked[p]) begin
              m_locked[p] = 1; m_move[p] = sv[p];
            end
          if (both) m_phase = PH_FIRE;
        end
        PH_FIRE: begin
          m_phase = PH_WAIT;
          m_waited = 0;
        end
        PH_WAIT: begin
          if (res_valid) begin
            if (res_code == 2'b01 && m_score[0] < WIN) m_score[0]++;
            if (res_code == 2'b10 && m_score[1] < WIN) m_score[1]++;
            m_locked[0] = 0; m_locked[1] = 0;
            m_phase = (m_score[0] == WIN || m_score[1] == WIN) ? PH_DONE : PH_COLLECT;
          end else begin
            m_waited++;
`ifdef RPS_ROUND_TIMEOUT_EN
            if (m_waited == TMO) begin
              m_err = 1;
              m_locked[0] = 0; m_locked[1] = 0;
              m_phase = PH_COLLECT;
            end
`endif
          end
        end
        default: ;
      endcase
    end
    for (int p = 0; p < 2; p++) begin
      m_run[p] = (raw[p] == m_last[p]) ? m_run[p] + 1 : 1;
      m_last[p] = raw[p];
      prev = m_level[p];
      if (m_run[p] >= DEB) m_level[p] = raw[p];
      m_rise[p] = m_level[p] && !prev;
    end
  endtask

  task automatic compare_all();
    int exp_gw;
    exp_gw = (m_phase == PH_FIRE) ? (1 + m_move[0] * 2 + m_move[1] * 8) : 0;
    check("game_word",  32'(game_word),  32'(exp_gw));
    check("p1_locked",  32'(p1_locked),  32'(m_locked[0]));
    check("p2_locked",  32'(p2_locked),  32'(m_locked[1]));
    check("busy",       32'(busy),       32'(m_phase == PH_FIRE || m_phase == PH_WAIT));
    check("p1_score",   32'(p1_score),   32'(m_score[0]));
    check("p2_score",   32'(p2_score),   32'(m_score[1]));
    check("match_over", 32'(match_over), 32'(m_phase == PH_DONE));
    check("round_err",  32'(round_err),  32'(m_err));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold_locks(input logic [1:0] s1, input logic [1:0] s2, input int cycles);
    p1_sel = s1; p2_sel = s2; p1_lock = 1'b1; p2_lock = 1'b1;
    repeat (cycles) tick();
    p1_lock = 1'b0; p2_lock = 1'b0;
  endtask

  task automatic play_round(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] code);
    hold_locks(s1, s2, 6);
    tick();
    res_valid = 1'b1; res_code = code;
    tick();
    res_valid = 1'b0;
    tick();
    $display("round p1=%0d p2=%0d code=%0d -> score %0d:%0d", s1, s2, code, p1_score, p2_score);
  endtask

  int seg_left[2];
  int fires;

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    $display("reset state checked");
    rst_n = 1'b1;
    tick();

    // First round: P1 rock, P2 paper, P2 wins.
    hold_locks(2'b00, 2'b01, 6);
    $display("fire word 0x%02h busy=%0d", game_word, busy);
    tick();
    res_valid = 1'b1; res_code = 2'b10;
    tick();
    res_valid = 1'b0;
    tick();
    $display("result P2 win -> score %0d:%0d", p1_score, p2_score);

    // Short pulses and invalid moves must never lock.
    repeat (3) begin
      p1_lock = 1'b1; p2_lock = 1'b1;
      repeat (2) tick();
      p1_lock = 1'b0; p2_lock = 1'b0;
      repeat (2) tick();
    end
    hold_locks(2'b11, 2'b11, 6);
    repeat (3) tick();
    $display("short pulses / invalid sel -> locks %0d%0d", p1_locked, p2_locked);

    // Three P1 wins end the match; presses in DONE are ignored.
    repeat (3) play_round(2'b10, 2'b01, 2'b01);
    hold_locks(2'b00, 2'b00, 8);
    repeat (2) tick();
    $display("match over=%0d locks %0d%0d", match_over, p1_locked, p2_locked);
    new_match = 1'b1;
    tick();
    new_match = 1'b0;
    tick();
    $display("new_match -> score %0d:%0d", p1_score, p2_score);

    // Withheld result: timeout abort if enabled, otherwise wait indefinitely.
    hold_locks(2'b01, 2'b10, 6);
    repeat (TMO + 5) tick();
    $display("withheld result -> busy=%0d", busy);
    res_valid = 1'b1; res_code = 2'b00;
    tick();
    res_valid = 1'b0;
    tick();

    // Reset during WAIT clears every output immediately.
    hold_locks(2'b10, 2'b00, 6);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    $display("async reset in WAIT -> word 0x%02h busy=%0d", game_word, busy);
    @(negedge clk);
    rst_n = 1'b1;
    play_round(2'b01, 2'b00, 2'b01);

    // Randomized traffic.
    seg_left[0] = 0; seg_left[1] = 0;
    fires = 0;
    for (int c = 0; c < 3000; c++) begin
      if (seg_left[0] == 0) begin
        p1_lock = 1'($urandom_range(0, 1));
        p1_sel = 2'($urandom_range(0, 3));
        seg_left[0] = $urandom_range(1, 8);
      end
      if (seg_left[1] == 0) begin
        p2_lock = 1'($urandom_range(0, 1));
        p2_sel = 2'($urandom_range(0, 3));
        seg_left[1] = $urandom_range(1, 8);
      end
      seg_left[0]--; seg_left[1]--;
      res_valid = ($urandom_range(0, 5) == 0);
      res_code = 2'($urandom_range(0, 3));
      new_match = (m_phase == PH_DONE) ? ($urandom_range(0, 19) == 0)
                                       : ($urandom_range(0, 299) == 0);
      tick();
      if (game_word[0]) begin
        fires++;
        $display("random fire #%0d word 0x%02h score %0d:%0d", fires, game_word, p1_score, p2_score);
      end
    end
    p1_lock = 1'b0; p2_lock = 1'b0; res_valid = 1'b0; new_match = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
